// File: rtl/jtpang_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_pkg
//  Description : Shared types and constants for the object-DMA bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtpang_pkg;

    // Bus arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } dma_state_t;

    // Upper VRAM address bits presented while the DMA engine owns the bus
    localparam logic [2:0] C_DMA_MSB_DEF = 3'b111;

    // Width of the CPU-release delay counter
    localparam int C_REL_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/jtpang_dmabus_trig.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_dmabus_trig
//  Description : Rising-edge detector for the DMA trigger port write. Fires
//                once on the first enabled tick of an access; further ticks
//                of the same held access are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpang_dmabus_trig (
    input  logic clk,
    input  logic rst,
    input  logic i_cen,
    input  logic i_sel,
    output logic o_fire
);

    logic r_last;

    // Remember the select level seen at the previous enabled tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (i_cen) begin
            r_last <= i_sel;
        end
    end

    assign o_fire = i_cen & i_sel & ~r_last;

endmodule
`default_nettype wire

// File: rtl/jtpang_dmabus.sv
`default_nettype none
// ============================================================================
//  Module      : jtpang_dmabus
//  Description : Arbitrates VRAM between the CPU and the object DMA engine.
//                Grants the bus only between CPU memory/IO cycles, holds the
//                CPU through a short release tail, and turns CPU writes to
//                the DMA port into single-clock start pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpang_dmabus
    import jtpang_pkg::*;
#(
    parameter logic [2:0] DMA_MSB = C_DMA_MSB_DEF,
    parameter int         REL_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cen,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        dmaport_cs,
    input  logic        wr_n,
    input  logic [11:0] cpu_addr,
    input  logic        busrq,
    input  logic [8:0]  dma_addr,
    output logic        busak_n,
    output logic        cpu_hold,
    output logic        dma_go,
    output logic [11:0] vram_addr
);

    localparam logic [C_REL_CNT_W-1:0] C_REL_LAST = C_REL_CNT_W'(REL_DLY - 1);

    dma_state_t             r_state;
    logic                   r_busak_n;
    logic                   r_cpu_hold;
    logic                   r_dma_go;
    logic                   r_pending;
    logic [C_REL_CNT_W-1:0] r_rel_cnt;
    logic                   w_trig;
    logic                   w_cpu_idle;

    jtpang_dmabus_trig u_trig (
        .clk    (clk),
        .rst    (rst),
        .i_cen  (cpu_cen),
        .i_sel  (dmaport_cs & ~wr_n),
        .o_fire (w_trig)
    );

    // The CPU is between bus cycles only when neither request is active
    assign w_cpu_idle = cpu_mreq_n & cpu_iorq_n;

    // Arbiter FSM, release counter and pending-trigger handling
    always_ff @(posedge clk) begin
        r_dma_go <= 1'b0;
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busak_n  <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_pending  <= 1'b0;
            r_rel_cnt  <= '0;
        end else if (cpu_cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (busrq) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A dropped request aborts before any grant is given
                    if (!busrq) begin
                        r_state <= ST_IDLE;
                    end else if (w_cpu_idle) begin
                        r_state    <= ST_GRANT;
                        r_busak_n  <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!busrq) begin
                        r_state   <= ST_RELEASE;
                        r_busak_n <= 1'b1;
                        r_rel_cnt <= '0;
                    end
                end
                ST_RELEASE: begin
                    // A new request here waits for IDLE, so grants never chain
                    if (r_rel_cnt == C_REL_LAST) begin
                        r_state    <= ST_IDLE;
                        r_cpu_hold <= 1'b0;
                        r_rel_cnt  <= '0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busak_n  <= 1'b1;
                    r_cpu_hold <= 1'b0;
                end
            endcase

            // Only one trigger may be outstanding; extras are dropped
            if (r_pending && (r_state == ST_IDLE)) begin
                r_dma_go  <= 1'b1;
                r_pending <= 1'b0;
            end else if (w_trig) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign busak_n   = r_busak_n;
    assign cpu_hold  = r_cpu_hold;
    assign dma_go    = r_dma_go;
    assign vram_addr = r_busak_n ? cpu_addr : {DMA_MSB, dma_addr};

endmodule
`default_nettype wire
